// File: rtl/pe_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pe_seq_ctrl
// Brief    : Per-pixel cal_start / PE_reset / PE_finish sequencer for the
//            16-PE convolution sub-top, with OFM raster walk and ack counting.
// Revision : 1.0  initial release
// ============================================================================
module pe_seq_ctrl #(
  parameter int NUM_PE        = 16,
  parameter int CYC_PER_PIX   = 36,
  parameter int PRE_DELAY     = 3,
  parameter int OFM_W         = 56,
  parameter int OFM_H         = 56,
  parameter int DRAIN_TIMEOUT = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     clear,
  input  logic                     pause,
  input  logic [NUM_PE-1:0]        pe_mask,
  input  logic [NUM_PE-1:0]        valid,
  output logic                     cal_start,
  output logic [NUM_PE-1:0]        PE_reset,
  output logic [NUM_PE-1:0]        PE_finish,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(OFM_H)-1:0] row,
  output logic [$clog2(OFM_W)-1:0] col
);

  localparam int c_row_w = $clog2(OFM_H);
  localparam int c_col_w = $clog2(OFM_W);
  localparam int c_pix_w = $clog2(OFM_W * OFM_H + 1);
  localparam int c_max_a = (PRE_DELAY > CYC_PER_PIX) ? PRE_DELAY : CYC_PER_PIX;
  localparam int c_max_b = (c_max_a > DRAIN_TIMEOUT) ? c_max_a : DRAIN_TIMEOUT;
  localparam int c_cnt_w = $clog2(c_max_b + 1);

  localparam logic [c_pix_w-1:0] c_total      = c_pix_w'(OFM_W * OFM_H);
  localparam logic [c_cnt_w-1:0] c_warm_last  = c_cnt_w'(PRE_DELAY - 1);
  localparam logic [c_cnt_w-1:0] c_acc_last   = c_cnt_w'(CYC_PER_PIX - 3);
  localparam logic [c_cnt_w-1:0] c_drain_last = c_cnt_w'(DRAIN_TIMEOUT - 1);
  localparam logic [c_col_w-1:0] c_col_last   = c_col_w'(OFM_W - 1);
  localparam logic [c_row_w-1:0] c_row_last   = c_row_w'(OFM_H - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WARMUP = 3'd1,
    S_RST    = 3'd2,
    S_ACC    = 3'd3,
    S_FIN    = 3'd4,
    S_HOLD   = 3'd5,
    S_DRAIN  = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic [c_pix_w-1:0]   r_issued;
  logic [c_pix_w-1:0]   w_issued_nxt;
  logic [c_pix_w-1:0]   r_acked;
  logic [c_pix_w-1:0]   w_acked_nxt;
  logic [NUM_PE-1:0]    r_mask;
  logic [NUM_PE-1:0]    w_mask_nxt;
  logic [c_row_w-1:0]   w_row_nxt;
  logic [c_col_w-1:0]   w_col_nxt;
  logic                 w_err_nxt;
  logic                 w_done_nxt;
  logic                 w_ack_hit;

  // An all-zero mask never acknowledges, so such a run ends by timeout.
  assign w_ack_hit = (r_mask != '0) && ((valid & r_mask) == r_mask);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_issued_nxt = r_issued;
    w_acked_nxt  = r_acked;
    w_mask_nxt   = r_mask;
    w_row_nxt    = row;
    w_col_nxt    = col;
    w_err_nxt    = err;
    w_done_nxt   = 1'b0;

    if ((r_state != S_IDLE) && w_ack_hit && (r_acked != c_total)) begin
      w_acked_nxt = r_acked + c_pix_w'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_mask_nxt   = pe_mask;
          w_cnt_nxt    = '0;
          w_issued_nxt = '0;
          w_acked_nxt  = '0;
          w_row_nxt    = '0;
          w_col_nxt    = '0;
          w_err_nxt    = 1'b0;
          w_state_nxt  = S_WARMUP;
        end
      end
      S_WARMUP: begin
        if (r_cnt == c_warm_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_RST;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end
      S_RST: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_ACC;
      end
      S_ACC: begin
        if (r_cnt == c_acc_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_FIN;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end
      S_FIN: begin
        w_issued_nxt = r_issued + c_pix_w'(1);
        w_cnt_nxt    = '0;
        if (col == c_col_last) begin
          w_col_nxt = '0;
          w_row_nxt = (row == c_row_last) ? '0 : row + c_row_w'(1);
        end else begin
          w_col_nxt = col + c_col_w'(1);
        end
        if (w_issued_nxt == c_total) begin
          w_state_nxt = S_DRAIN;
        end else if (pause) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_RST;
        end
      end
      S_HOLD: begin
        if (!pause) begin
          w_state_nxt = S_RST;
        end
      end
      S_DRAIN: begin
        if (r_acked == c_total) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == c_drain_last) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort takes priority over everything, including a same-cycle start.
    if (clear) begin
      w_state_nxt  = S_IDLE;
      w_cnt_nxt    = '0;
      w_issued_nxt = '0;
      w_acked_nxt  = '0;
      w_mask_nxt   = '0;
      w_row_nxt    = '0;
      w_col_nxt    = '0;
      w_err_nxt    = 1'b0;
      w_done_nxt   = 1'b0;
    end
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe while staying free of input-to-output paths.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_issued  <= '0;
      r_acked   <= '0;
      r_mask    <= '0;
      row       <= '0;
      col       <= '0;
      cal_start <= 1'b0;
      busy      <= 1'b0;
      PE_reset  <= '0;
      PE_finish <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_issued  <= w_issued_nxt;
      r_acked   <= w_acked_nxt;
      r_mask    <= w_mask_nxt;
      row       <= w_row_nxt;
      col       <= w_col_nxt;
      cal_start <= (w_state_nxt != S_IDLE);
      busy      <= (w_state_nxt != S_IDLE);
      PE_reset  <= (w_state_nxt == S_RST) ? w_mask_nxt : '0;
      PE_finish <= (w_state_nxt == S_FIN) ? w_mask_nxt : '0;
      done      <= w_done_nxt;
      err       <= w_err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_seq_ctrl
// Brief    : Directed self-checking bench for pe_seq_ctrl (4x3 OFM, 6 cyc/pix).
// Revision : 1.0  initial release
// ============================================================================
module tb_pe_seq_ctrl;

  localparam int NUM_PE = 16;
  localparam int CYC    = 6;
  localparam int PRE    = 3;
  localparam int W      = 4;
  localparam int H      = 3;
  localparam int DT     = 256;
  localparam int N      = W * H;
  localparam int LAST_FIN = PRE + N * CYC - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              clear;
  logic              pause;
  logic [NUM_PE-1:0] pe_mask;
  logic [NUM_PE-1:0] valid;
  logic              cal_start;
  logic [NUM_PE-1:0] PE_reset;
  logic [NUM_PE-1:0] PE_finish;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        row;
  logic [1:0]        col;

  pe_seq_ctrl #(
    .NUM_PE(NUM_PE), .CYC_PER_PIX(CYC), .PRE_DELAY(PRE),
    .OFM_W(W), .OFM_H(H), .DRAIN_TIMEOUT(DT)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .pause(pause),
    .pe_mask(pe_mask), .valid(valid), .cal_start(cal_start),
    .PE_reset(PE_reset), .PE_finish(PE_finish), .busy(busy), .done(done),
    .err(err), .row(row), .col(col)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-run record, filled by run_layer (cycle 0 = first cycle after start edge).
  int          n_rst, n_fin, done_k, end_k;
  int          rst_k [32];
  int          rst_r [32];
  int          rst_c [32];
  int          fin_k [32];
  logic [15:0] rst_v [32];
  logic [15:0] fin_v [32];
  logic [15:0] or_acc;
  logic        end_err, cal0, err0;

  task automatic run_layer(input logic [15:0] m, input logic [15:0] resp,
                           input int pause_pix, input bit drop_last);
    bit h1, h2, h3;
    int acks, pause_left;
    h1 = 0; h2 = 0; h3 = 0; acks = 0; pause_left = 0;
    n_rst = 0; n_fin = 0; done_k = -1; end_k = -1; or_acc = '0;
    @(negedge clk); start = 1'b1; pe_mask = m;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) begin cal0 = cal_start; err0 = err; end
      or_acc = or_acc | PE_reset | PE_finish;
      if (PE_reset != '0 && n_rst < 32) begin
        rst_k[n_rst] = k; rst_v[n_rst] = PE_reset;
        rst_r[n_rst] = int'(row); rst_c[n_rst] = int'(col);
        n_rst++;
      end
      if (PE_finish != '0 && n_fin < 32) begin
        fin_k[n_fin] = k; fin_v[n_fin] = PE_finish;
        n_fin++;
      end
      if (done) done_k = k;
      if (!busy) begin end_k = k; end_err = err; break; end
      if (pause_left > 0) begin
        pause_left--;
        if (pause_left == 0) pause = 1'b0;
      end
      if (PE_finish != '0 && (n_fin - 1) == pause_pix) begin
        pause = 1'b1; pause_left = 5;
      end
      // Datapath model: ack two cycles after each FIN.
      h3 = h2; h2 = h1; h1 = (PE_finish != '0);
      if (h3) begin
        valid = (drop_last && acks == N - 1) ? '0 : resp;
        acks++;
      end else begin
        valid = '0;
      end
    end
    pause = 1'b0; valid = '0;
    if (end_k < 0) chk("run_end_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_pixels(input string tag, input logic [15:0] m, input int pause_pix);
    int shift;
    chk({tag, "_n_rst"}, n_rst, N);
    chk({tag, "_n_fin"}, n_fin, N);
    for (int i = 0; i < N && i < n_rst; i++) begin
      shift = (pause_pix >= 0 && i > pause_pix) ? 5 : 0;
      chk($sformatf("%s_rst_k%0d", tag, i), rst_k[i], PRE + i * CYC + shift);
      chk($sformatf("%s_rst_v%0d", tag, i), 32'(rst_v[i]), 32'(m));
      chk($sformatf("%s_row%0d", tag, i), rst_r[i], i / W);
      chk($sformatf("%s_col%0d", tag, i), rst_c[i], i % W);
    end
    for (int i = 0; i < N && i < n_fin; i++) begin
      shift = (pause_pix >= 0 && i > pause_pix) ? 5 : 0;
      chk($sformatf("%s_fin_k%0d", tag, i), fin_k[i], PRE + i * CYC + CYC - 1 + shift);
      chk($sformatf("%s_fin_v%0d", tag, i), 32'(fin_v[i]), 32'(m));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; clear = 1'b0; pause = 1'b0;
    pe_mask = '0; valid = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cal_start", 32'(cal_start), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_pe_reset",  32'(PE_reset),  32'd0);
    chk("rst_pe_finish", 32'(PE_finish), 32'd0);
    chk("rst_row_col",   32'({row, col}), 32'd0);
    @(negedge clk); reset = 1'b1;

    // A: nominal run, full mask
    run_layer(16'hFFFF, 16'hFFFF, -1, 1'b0);
    chk("A_cal0", 32'(cal0), 32'd1);
    check_pixels("A", 16'hFFFF, -1);
    chk("A_done_k", done_k, LAST_FIN + 4);
    chk("A_end_k",  end_k,  LAST_FIN + 4);
    chk("A_err",    32'(end_err), 32'd0);
    chk("A_cal_end", 32'(cal_start), 32'd0);

    // B: pause held 5 cycles from the FIN of pixel 10
    run_layer(16'hFFFF, 16'hFFFF, 10, 1'b0);
    check_pixels("B", 16'hFFFF, 10);
    chk("B_gap10", rst_k[11] - fin_k[10], 6);
    chk("B_done_k", done_k, LAST_FIN + 4 + 5);

    // C: partial mask 00FF
    run_layer(16'h00FF, 16'h00FF, -1, 1'b0);
    check_pixels("C", 16'h00FF, -1);
    chk("C_upper", 32'(or_acc[15:8]), 32'd0);
    chk("C_done_k", done_k, LAST_FIN + 4);
    chk("C_err", 32'(end_err), 32'd0);

    // D: final ack withheld -> drain timeout
    run_layer(16'hFFFF, 16'hFFFF, -1, 1'b1);
    chk("D_done_k", done_k, -1);
    chk("D_end_k",  end_k,  LAST_FIN + 1 + DT);
    chk("D_err",    32'(end_err), 32'd1);
    repeat (3) @(negedge clk);
    chk("D_err_sticky", 32'(err), 32'd1);
    chk("D_busy", 32'(busy), 32'd0);

    // E: next start clears err and completes
    run_layer(16'hFFFF, 16'hFFFF, -1, 1'b0);
    chk("E_err0", 32'(err0), 32'd0);
    chk("E_done_k", done_k, LAST_FIN + 4);

    // F: zero mask sequences silently and times out
    run_layer(16'h0000, 16'hFFFF, -1, 1'b0);
    chk("F_n_rst", n_rst, 0);
    chk("F_done_k", done_k, -1);
    chk("F_end_k", end_k, LAST_FIN + 1 + DT);
    chk("F_err", 32'(end_err), 32'd1);

    // G: clear with start during ACC of pixel 5
    @(negedge clk); start = 1'b1; pe_mask = 16'hFFFF;
    @(negedge clk); start = 1'b0;
    repeat (35) @(negedge clk);
    chk("G_busy_pre", 32'(busy), 32'd1);
    chk("G_err_pre",  32'(err),  32'd0);
    chk("G_rc_pre",   32'({row, col}), 32'({2'd1, 2'd1}));
    clear = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; start = 1'b0;
    chk("G_busy",      32'(busy),      32'd0);
    chk("G_cal_start", 32'(cal_start), 32'd0);
    chk("G_pulses",    32'(PE_reset | PE_finish), 32'd0);
    chk("G_row_col",   32'({row, col}), 32'd0);
    chk("G_done",      32'(done),      32'd0);
    @(posedge clk); #1;
    chk("G_start_ign", 32'(busy), 32'd0);

    // H: asynchronous reset mid-ACC
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (35) @(negedge clk);
    chk("H_busy_pre", 32'(cal_start), 32'd1);
    reset = 1'b0;
    #1;
    chk("H_cal_start", 32'(cal_start), 32'd0);
    chk("H_busy",      32'(busy),      32'd0);
    chk("H_row_col",   32'({row, col}), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
